// File: rtl/mplier_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mplier_pkg : shared types and helpers for the radix-4 Booth multiplier
// Rev 1.0
// ---------------------------------------------------------------------------
package mplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_P1   = 3'd1,
    DIG_P2   = 3'd2,
    DIG_M1   = 3'd3,
    DIG_M2   = 3'd4
  } digit_t;

  // Recode {b[2i+1], b[2i], b[2i-1]} into a digit in {-2..+2}
  function automatic digit_t booth_decode(input logic [2:0] bits);
    digit_t d;
    case (bits)
      3'b001, 3'b010: d = DIG_P1;
      3'b011:         d = DIG_P2;
      3'b100:         d = DIG_M2;
      3'b101, 3'b110: d = DIG_M1;
      default:        d = DIG_ZERO;
    endcase
    return d;
  endfunction

  function automatic int booth_digits(input int w);
    return w / 2 + 1;
  endfunction

  function automatic int acc_width(input int w);
    return 2 * w + 4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_r4_digit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// booth_r4_digit : one radix-4 Booth digit times the extended multiplicand
// Rev 1.0
// ---------------------------------------------------------------------------
module booth_r4_digit
  import mplier_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [2:0]   bits,
  input  logic [W+1:0] a_ext,
  output logic [W+2:0] pp
);

  digit_t       digit;
  logic [W+2:0] a_x1;
  logic [W+2:0] a_x2;

  // One extra bit keeps -2A representable for the most negative operand
  always_comb begin
    digit = booth_decode(bits);
    a_x1  = {a_ext[W+1], a_ext};
    a_x2  = {a_ext, 1'b0};
    case (digit)
      DIG_P1:  pp = a_x1;
      DIG_P2:  pp = a_x2;
      DIG_M1:  pp = -a_x1;
      DIG_M2:  pp = -a_x2;
      default: pp = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/booth_seq_mplier.sv
`default_nettype none
// ---------------------------------------------------------------------------
// booth_seq_mplier : sequential W x W radix-4 Booth multiplier, valid/ready
// Optional build macro MPLIER_EARLY_TERM_EN: stop once remaining digits are 0
// Rev 1.0
// ---------------------------------------------------------------------------
module booth_seq_mplier
  import mplier_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int N  = booth_digits(W);
  localparam int CW = $clog2(N + 1);
  localparam int AW = acc_width(W);
  localparam int XW = W + 2;

  state_t          state;
  state_t          state_nxt;
  logic [XW-1:0]   a_ext_r;
  logic [XW-1:0]   b_sh;
  logic            guard;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   acc;

  logic [W+2:0]    pp;
  logic [AW-1:0]   pp_aligned;
  logic [AW-1:0]   acc_nxt;
  logic [XW-1:0]   b_nxt;
  logic            last_digit;
  logic            finish;

  booth_r4_digit #(.W(W)) u_digit (
    .bits  ({b_sh[1], b_sh[0], guard}),
    .a_ext (a_ext_r),
    .pp    (pp)
  );

  // Multiplier bits are consumed from the bottom of a shift register; the
  // accumulator stays put and each partial product is aligned by 2*cnt.
  always_comb begin
    b_nxt      = {{2{b_sh[XW-1]}}, b_sh[XW-1:2]};
    pp_aligned = {{(AW-(W+3)){pp[W+2]}}, pp} << {cnt, 1'b0};
    acc_nxt    = acc + pp_aligned;
    last_digit = (cnt == CW'(N - 1));
  end

`ifdef MPLIER_EARLY_TERM_EN
  logic [XW:0] remaining;
  always_comb begin
    remaining = {b_nxt, b_sh[1]};
    finish    = last_digit | (&remaining) | ~(|remaining);
  end
`else
  always_comb begin
    finish = last_digit;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (finish)    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ext_r <= '0;
      b_sh    <= '0;
      guard   <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_ext_r <= is_signed ? {{2{a[W-1]}}, a} : {2'b00, a};
            b_sh    <= is_signed ? {{2{b[W-1]}}, b} : {2'b00, b};
            guard   <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
          end
        end
        BUSY: begin
          acc   <= acc_nxt;
          b_sh  <= b_nxt;
          guard <= b_sh[1];
          cnt   <= cnt + CW'(1);
          if (finish) product <= acc_nxt[2*W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
`default_nettype wire
